// File: rtl/adder_pipe_nbit.sv
// Pipelined carry-chain adder: WIDTH bits split into STAGES chunks, one chunk per register stage.
// Optional subtract mode (extra `sub` port) is enabled by defining ADDER_PIPE_SUB_EN.
module adder_pipe_nbit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
`ifdef ADDER_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_OUT,
    output logic             OVF
);
    localparam int CW = WIDTH / STAGES;

    logic             advance;
    logic             valid_reg [STAGES];
    logic             carry_reg [STAGES];
    // Per stage: sum chunks already computed in the low bits, untouched A bits above.
    logic [WIDTH-1:0] acc_reg   [STAGES];
    logic             ovf_reg;

    assign advance   = !valid_reg[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_reg[STAGES-1];
    assign S         = acc_reg[STAGES-1];
    assign C_OUT     = carry_reg[STAGES-1];
    assign OVF       = ovf_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO  = gi * CW;
        localparam int REM = WIDTH - (gi + 1) * CW;

        logic [WIDTH-1:0]    acc_src;
        logic [WIDTH-LO-1:0] b_src;
        logic                valid_src;
        logic                cin;
        logic [CW-1:0]       a_chunk;
        logic [CW-1:0]       b_eff;
        logic [CW-1:0]       sum_chunk;
        logic                cout;
        logic [WIDTH-1:0]    acc_next;
`ifdef ADDER_PIPE_SUB_EN
        logic                sub_src;
`endif

        if (gi == 0) begin : g_first
            assign acc_src   = A;
            assign b_src     = B;
            assign valid_src = in_valid;
`ifdef ADDER_PIPE_SUB_EN
            assign sub_src   = sub;
            assign cin       = sub | c_in;
`else
            assign cin       = c_in;
`endif
        end else begin : g_next
            assign acc_src   = acc_reg[gi-1];
            assign b_src     = g_stage[gi-1].g_rem.b_rem_reg;
            assign valid_src = valid_reg[gi-1];
            assign cin       = carry_reg[gi-1];
`ifdef ADDER_PIPE_SUB_EN
            assign sub_src   = g_stage[gi-1].g_rem.sub_reg;
`endif
        end

        assign a_chunk = acc_src[LO +: CW];
`ifdef ADDER_PIPE_SUB_EN
        assign b_eff   = sub_src ? ~b_src[CW-1:0] : b_src[CW-1:0];
`else
        assign b_eff   = b_src[CW-1:0];
`endif
        assign {cout, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_eff} + {{CW{1'b0}}, cin};

        always_comb begin
            acc_next            = acc_src;
            acc_next[LO +: CW]  = sum_chunk;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                carry_reg[gi] <= 1'b0;
                acc_reg[gi]   <= '0;
            end else if (advance) begin
                valid_reg[gi] <= valid_src;
                carry_reg[gi] <= cout;
                acc_reg[gi]   <= acc_next;
            end
        end

        // B chunks not yet consumed ride the skew pipeline toward later stages.
        if (REM > 0) begin : g_rem
            logic [REM-1:0] b_rem_reg;
`ifdef ADDER_PIPE_SUB_EN
            logic           sub_reg;
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_rem_reg <= '0;
`ifdef ADDER_PIPE_SUB_EN
                    sub_reg   <= 1'b0;
`endif
                end else if (advance) begin
                    b_rem_reg <= b_src[WIDTH-LO-1:CW];
`ifdef ADDER_PIPE_SUB_EN
                    sub_reg   <= sub_src;
`endif
                end
            end
        end

        if (gi == STAGES - 1) begin : g_last
            logic ovf_next;
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign ovf_next = a_chunk[CW-1] ^ b_eff[CW-1] ^ sum_chunk[CW-1] ^ cout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (advance) begin
                    ovf_reg <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed self-checking bench for adder_pipe_nbit (WIDTH=32, STAGES=2).
module tb_adder_pipe_nbit;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_OUT;
    logic             OVF;
`ifdef ADDER_PIPE_SUB_EN
    logic             sub;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [33:0] exp_q [$];

    adder_pipe_nbit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .c_in     (c_in),
`ifdef ADDER_PIPE_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .C_OUT    (C_OUT),
        .OVF      (OVF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single transaction on an idle pipe, checking latency and result.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic [31:0] es, input logic ec, input logic eo);
        A = a; B = b; c_in = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_S"}, 64'(S), 64'(es));
        chk({tag, "_C"}, 64'(C_OUT), 64'(ec));
        chk({tag, "_OVF"}, 64'(OVF), 64'(eo));
        $display("txn %s: A=%h B=%h c_in=%b -> S=%h C_OUT=%b OVF=%b", tag, a, b, ci, S, C_OUT, OVF);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] full;
        logic        rovf;
        logic [33:0] expv;
        int          got;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; c_in = 1'b0; out_ready = 1'b1;
`ifdef ADDER_PIPE_SUB_EN
        sub = 1'b0;
`endif
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_S", 64'(S), 64'd0);
        chk("rst_C", 64'(C_OUT), 64'd0);
        chk("rst_OVF", 64'(OVF), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        send_one("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_one("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one("xchunk", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        send_one("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        send_one("cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        send_one("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        send_one("cinchain", 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        step();

        // Back-to-back stream with a reference model in the queue.
        got = 0;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                ra = $urandom(); rb = $urandom(); rc = 1'($urandom_range(0, 1));
                full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
                rovf = (ra[31] == rb[31]) && (full[31] != ra[31]);
                exp_q.push_back({rovf, full[32], full[31:0]});
                A = ra; B = rb; c_in = rc; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", 64'd1, 64'd0);
                end else begin
                    expv = exp_q.pop_front();
                    chk("stream", {30'd0, OVF, C_OUT, S}, {30'd0, expv});
                    $display("txn stream %0d: S=%h C_OUT=%b OVF=%b", got, S, C_OUT, OVF);
                    got++;
                end
            end
        end
        chk("stream_count", 64'(got), 64'd100);
        chk("stream_left", 64'(exp_q.size()), 64'd0);

        // Backpressure: hold the first result for five cycles with a third operand offered.
        out_ready = 1'b0;
        A = 32'h0000_0001; B = 32'h0000_0002; c_in = 1'b0; in_valid = 1'b1;
        #1;
        chk("bp_ready_idle", 64'(in_ready), 64'd1);
        step();
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; c_in = 1'b1;
        chk("bp_not_yet", 64'(out_valid), 64'd0);
        step();
        A = 32'h4000_0000; B = 32'h4000_0000; c_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_S", 64'(S), 64'h3);
            chk("bp_hold_C", 64'(C_OUT), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        $display("txn bp1: S=%h C_OUT=%b OVF=%b held", S, C_OUT, OVF);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp2_valid", 64'(out_valid), 64'd1);
        chk("bp2_S", {31'd0, C_OUT, S}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        chk("bp2_OVF", 64'(OVF), 64'd0);
        $display("txn bp2: S=%h C_OUT=%b OVF=%b", S, C_OUT, OVF);
        step();
        chk("bp3_valid", 64'(out_valid), 64'd1);
        chk("bp3_S", {31'd0, C_OUT, S}, {31'd0, 1'b0, 32'h8000_0000});
        chk("bp3_OVF", 64'(OVF), 64'd1);
        $display("txn bp3: S=%h C_OUT=%b OVF=%b", S, C_OUT, OVF);
        step();
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // Reset with two transactions in flight.
        A = 32'h0000_0010; B = 32'h0000_0020; c_in = 1'b0; in_valid = 1'b1;
        step();
        A = 32'h0000_0030; B = 32'h0000_0040;
        step();
        in_valid = 1'b0;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_S", 64'(S), 64'd0);
        step();
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) got++;
        end
        chk("mid_no_stale", 64'(got), 64'd0);
        $display("txn reset_mid: in-flight results discarded count=%0d", got);

`ifdef ADDER_PIPE_SUB_EN
        sub = 1'b1;
        send_one("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
